// File: rtl/viterbi_acs_pmu.sv
// Add-compare-select and path-metric unit for a rate-1/2, K=3 hard-decision
// Viterbi decoder: four saturating path metrics plus per-state survivor bits.
module viterbi_acs_pmu #(
    parameter int PM_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                frame_start,
    input  logic [1:0]          rec_code,
    output logic                out_valid,
    output logic [3:0]          decision,
    output logic [1:0]          best_state,
    output logic [4*PM_W-1:0]   pm_flat,
    output logic [CNT_W-1:0]    step_cnt
);

    localparam logic [PM_W-1:0]  PM_MAX = {PM_W{1'b1}};
    localparam logic [PM_W:0]    SAT    = {1'b0, PM_MAX};
    localparam logic [CNT_W-1:0] ONE    = 1;

    logic [PM_W-1:0] pm     [4];
    logic [PM_W-1:0] base   [4];
    logic [PM_W:0]   cand   [4];
    logic [PM_W-1:0] pm_nxt [4];
    logic [PM_W:0]   cmin;
    logic [PM_W:0]   c0;
    logic [PM_W:0]   c1;
    logic [PM_W:0]   diff;
    logic [1:0]      nn;
    logic [1:0]      p0;
    logic [1:0]      p1;
    logic [3:0]      dec_nxt;
    logic [1:0]      best_nxt;

    // Encoder output for leaving state s with input bit u.
    function automatic logic [1:0] exp_code(input logic [1:0] s, input logic u);
        return {u ^ s[0], u ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [PM_W:0] bm(input logic [1:0] rc, input logic [1:0] e);
        logic [1:0] d;
        d = rc ^ e;
        return (PM_W+1)'(d[0]) + (PM_W+1)'(d[1]);
    endfunction

    always_comb begin
        dec_nxt  = '0;
        best_nxt = '0;
        cmin     = '1;
        nn       = '0;
        p0       = '0;
        p1       = '0;
        c0       = '0;
        c1       = '0;
        diff     = '0;
        for (int i = 0; i < 4; i++) begin
            base[i]   = frame_start ? ((i == 0) ? {PM_W{1'b0}} : PM_MAX) : pm[i];
            cand[i]   = '0;
            pm_nxt[i] = '0;
        end
        // Both predecessors of n share input bit n[1]; ties keep p0.
        for (int n = 0; n < 4; n++) begin
            nn = 2'(n);
            p0 = {nn[0], 1'b0};
            p1 = {nn[0], 1'b1};
            c0 = {1'b0, base[p0]} + bm(rec_code, exp_code(p0, nn[1]));
            c1 = {1'b0, base[p1]} + bm(rec_code, exp_code(p1, nn[1]));
            dec_nxt[n] = (c1 < c0);
            cand[n]    = (c1 < c0) ? c1 : c0;
            if (cand[n] < cmin) cmin = cand[n];
        end
        for (int i = 0; i < 4; i++) begin
            diff      = cand[i] - cmin;
            pm_nxt[i] = (diff > SAT) ? PM_MAX : diff[PM_W-1:0];
        end
        for (int i = 3; i >= 0; i--) begin
            if (cand[i] == cmin) best_nxt = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) pm[i] <= (i == 0) ? {PM_W{1'b0}} : PM_MAX;
            out_valid  <= 1'b0;
            decision   <= '0;
            best_state <= '0;
            step_cnt   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 4; i++) pm[i] <= pm_nxt[i];
                decision   <= dec_nxt;
                best_state <= best_nxt;
                step_cnt   <= frame_start ? ONE : step_cnt + ONE;
            end else if (frame_start) begin
                for (int i = 0; i < 4; i++) pm[i] <= (i == 0) ? {PM_W{1'b0}} : PM_MAX;
                step_cnt <= '0;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_flat
        assign pm_flat[g*PM_W +: PM_W] = pm[g];
    end

endmodule

// File: tb/tb_viterbi_acs_pmu.sv
// Randomised and directed checks of viterbi_acs_pmu against a forward
// trellis-enumeration model of the ACS and path-metric behaviour.
module tb_viterbi_acs_pmu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [1:0] rec_code = 2'b00;

    logic        out_valid;
    logic [3:0]  decision;
    logic [1:0]  best_state;
    logic [15:0] pm_flat;
    logic [7:0]  step_cnt;

    logic        out_valid2;
    logic [3:0]  decision2;
    logic [1:0]  best_state2;
    logic [15:0] pm_flat2;
    logic [1:0]  step_cnt2;

    viterbi_acs_pmu #(.PM_W(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .rec_code(rec_code), .out_valid(out_valid), .decision(decision),
        .best_state(best_state), .pm_flat(pm_flat), .step_cnt(step_cnt)
    );

    viterbi_acs_pmu #(.PM_W(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .frame_start(frame_start),
        .rec_code(rec_code), .out_valid(out_valid2), .decision(decision2),
        .best_state(best_state2), .pm_flat(pm_flat2), .step_cnt(step_cnt2)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_pm [4];
    int m_cnt = 0;
    int m_dec = 0;
    int m_best = 0;
    bit m_ov = 1'b0;
    logic [15:0] m_flat;

    int nb [4];
    int nc [4];
    int nd [4];
    int nn [4];
    int mn, nbest, nx, cc;

    function automatic int code_of(int s, int u);
        return ((u ^ (s & 1)) << 1) | (u ^ (s >> 1) ^ (s & 1));
    endfunction

    function automatic int hd(int a, int b);
        int x;
        x = a ^ b;
        return (x & 1) + ((x >> 1) & 1);
    endfunction

    // Enumerate every (state, input) branch; strict '<' keeps the lower predecessor on ties.
    always_comb begin
        mn = 1000;
        nbest = 0;
        nx = 0;
        cc = 0;
        for (int i = 0; i < 4; i++) begin
            nb[i] = frame_start ? ((i == 0) ? 0 : 15) : m_pm[i];
            nc[i] = 1000;
            nd[i] = 0;
            nn[i] = 0;
        end
        for (int s = 0; s < 4; s++) begin
            for (int u = 0; u < 2; u++) begin
                nx = 2 * u + s / 2;
                cc = nb[s] + hd(int'(rec_code), code_of(s, u));
                if (cc < nc[nx]) begin
                    nc[nx] = cc;
                    nd[nx] = s % 2;
                end
            end
        end
        for (int n = 0; n < 4; n++) if (nc[n] < mn) mn = nc[n];
        for (int n = 0; n < 4; n++) nn[n] = (nc[n] - mn > 15) ? 15 : nc[n] - mn;
        for (int n = 3; n >= 0; n--) if (nn[n] == 0) nbest = n;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_pm[i] <= (i == 0) ? 0 : 15;
            m_ov   <= 1'b0;
            m_dec  <= 0;
            m_best <= 0;
            m_cnt  <= 0;
        end else begin
            m_ov <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 4; i++) m_pm[i] <= nn[i];
                m_dec  <= nd[0] + 2 * nd[1] + 4 * nd[2] + 8 * nd[3];
                m_best <= nbest;
                m_cnt  <= frame_start ? 1 : (m_cnt + 1) % 256;
            end else if (frame_start) begin
                for (int i = 0; i < 4; i++) m_pm[i] <= (i == 0) ? 0 : 15;
                m_cnt <= 0;
            end
        end
    end

    always_comb m_flat = {4'(m_pm[3]), 4'(m_pm[2]), 4'(m_pm[1]), 4'(m_pm[0])};

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("decision", 32'(decision), m_dec);
            chk("best_state", 32'(best_state), m_best);
            chk("pm_flat", 32'(pm_flat), 32'(m_flat));
            chk("step_cnt", 32'(step_cnt), m_cnt);
            chk("step_cnt_w2", 32'(step_cnt2), m_cnt % 4);
            chk("pm_flat_w2", 32'(pm_flat2), 32'(m_flat));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit r, input bit fs, input bit iv, input logic [1:0] rc);
        rst = r;
        frame_start = fs;
        in_valid = iv;
        rec_code = rc;
        @(posedge clk);
        #1;
    endtask

    int bits [6];
    int codes [6];
    logic [3:0] decs [6];
    logic [1:0] sym [12];
    logic [5:0] decoded;
    logic [5:0] orig;
    logic [15:0] ref_pm;
    int ref_dec, ref_cnt, st, uu;
    int cnt_seq [5];

    initial begin
        send(1, 0, 0, 2'b00);
        chk_en = 1'b1;
        chk("rst_pm", 32'(pm_flat), 32'h0000fff0);
        chk("rst_ov", 32'(out_valid), 0);
        chk("rst_cnt", 32'(step_cnt), 0);
        chk("rst_best", 32'(best_state), 0);
        chk("rst_dec", 32'(decision), 0);

        send(0, 1, 1, 2'b00);
        chk("t1_pm", 32'(pm_flat), 32'h0000f2f0);
        chk("t1_dec", 32'(decision), 0);
        chk("t1_ov", 32'(out_valid), 1);
        chk("t1_cnt", 32'(step_cnt), 1);

        for (int k = 0; k < 20; k++) begin
            send(0, 0, 1, 2'b00);
            chk("zero_pm0", 32'(pm_flat[3:0]), 0);
            chk("zero_dec0", 32'(decision[0]), 0);
            chk("zero_best", 32'(best_state), 0);
        end
        chk("zero_cnt", 32'(step_cnt), 21);

        send(0, 1, 1, 2'b11);
        chk("t2_pm", 32'(pm_flat), 32'h0000f0f2);
        chk("t2_best", 32'(best_state), 2);
        chk("t2_dec", 32'(decision), 0);
        chk("t2_cnt", 32'(step_cnt), 1);

        // Encode 1,0,1,1,0,0, corrupt one bit of the third symbol, trace back.
        bits = '{1, 0, 1, 1, 0, 0};
        st = 0;
        for (int k = 0; k < 6; k++) begin
            codes[k] = code_of(st, bits[k]);
            st = 2 * bits[k] + st / 2;
            orig[k] = bits[k][0];
        end
        codes[2] = codes[2] ^ 1;
        for (int k = 0; k < 6; k++) begin
            send(0, k == 0, 1, 2'(codes[k]));
            decs[k] = decision;
        end
        chk("tb_best", 32'(best_state), 0);
        chk("tb_pm", 32'(pm_flat), 32'h00002220);
        st = 0;
        decoded = '0;
        for (int k = 5; k >= 0; k--) begin
            uu = st >> 1;
            decoded[k] = uu[0];
            st = ((st & 1) << 1) | int'(decs[k][st]);
        end
        chk("traceback", 32'(decoded), 32'(orig));

        // Same symbols with and without idle gaps must end identically.
        for (int k = 0; k < 12; k++) sym[k] = 2'($urandom_range(0, 3));
        for (int k = 0; k < 12; k++) send(0, k == 0, 1, sym[k]);
        ref_pm = m_flat;
        ref_dec = m_dec;
        ref_cnt = m_cnt;
        for (int k = 0; k < 12; k++) begin
            send(0, k == 0, 1, sym[k]);
            if (k == 4) begin
                send(0, 0, 0, 2'($urandom_range(0, 3)));
                chk("gap1_ov", 32'(out_valid), 0);
            end
            if (k == 8) begin
                for (int g = 0; g < 3; g++) begin
                    send(0, 0, 0, 2'($urandom_range(0, 3)));
                    chk("gap3_ov", 32'(out_valid), 0);
                end
            end
        end
        chk("gap_pm", 32'(pm_flat), 32'(ref_pm));
        chk("gap_dec", 32'(decision), ref_dec);
        chk("gap_cnt", 32'(step_cnt), ref_cnt);

        send(0, 1, 1, 2'b10);
        send(0, 0, 1, 2'b01);
        send(1, 0, 1, 2'b11);
        chk("midrst_pm", 32'(pm_flat), 32'h0000fff0);
        chk("midrst_ov", 32'(out_valid), 0);
        chk("midrst_cnt", 32'(step_cnt), 0);

        cnt_seq = '{1, 2, 3, 0, 1};
        for (int k = 0; k < 5; k++) begin
            send(0, k == 0, 1, 2'($urandom_range(0, 3)));
            chk("cnt_w2_seq", 32'(step_cnt2), cnt_seq[k]);
        end

        send(0, 1, 0, 2'b01);
        chk("fs_idle_pm", 32'(pm_flat), 32'h0000fff0);
        chk("fs_idle_cnt", 32'(step_cnt), 0);
        chk("fs_idle_ov", 32'(out_valid), 0);

        send(0, 1, 1, 2'($urandom_range(0, 3)));
        for (int k = 0; k < 300; k++) send(0, 0, 1, 2'($urandom_range(0, 3)));
        chk("wrap_cnt", 32'(step_cnt), 45);

        for (int k = 0; k < 3000; k++) begin
            send($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 75,
                 2'($urandom_range(0, 3)));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
